// File: rtl/core_cycle_monitor.sv
// Core cycle monitor: counts core cycles from reset and latches test completion
// (pass/fail/timeout) from a tohost write. Optional heartbeat: CORE_CYCLE_MONITOR_HEARTBEAT_EN.
module core_cycle_monitor #(
  parameter int WIDTH    = 32,
  parameter int HB_SHIFT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_limit,
  input  logic             io_tohost_valid,
  output logic             io_tohost_ready,
  input  logic [31:0]      io_tohost_bits,
  output logic [WIDTH-1:0] io_cycles,
  output logic             io_finished,
  output logic             io_pass,
  output logic [30:0]      io_exit_code,
  output logic             io_timeout,
  output logic [1:0]       io_state
`ifdef CORE_CYCLE_MONITOR_HEARTBEAT_EN
  ,
  output logic             io_heartbeat
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cycles;
  logic [30:0]      r_exit_code;

  logic             w_running;
  logic             w_term_write;
  logic             w_is_pass;
  logic             w_limit_hit;
  logic [WIDTH-1:0] w_cycles_inc;

  // Handshake: a tohost write is accepted on a rising clock edge when
  // io_tohost_valid & io_tohost_ready; ready is high only while running.
  assign w_running    = (r_state == ST_RUN);
  assign w_term_write = io_tohost_valid & w_running & io_tohost_bits[0];
  assign w_is_pass    = (io_tohost_bits == 32'h0000_0001);
  assign w_limit_hit  = (io_limit != '0) && (r_cycles >= io_limit);
  assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_cycles    <= '0;
      r_exit_code <= '0;
    end else if (w_running) begin
      // A terminating write outranks a timeout seen on the same edge; in both
      // cases the counter keeps the value that was compared.
      if (w_term_write) begin
        r_state     <= w_is_pass ? ST_PASS : ST_FAIL;
        r_exit_code <= w_is_pass ? 31'd0 : io_tohost_bits[31:1];
      end else if (w_limit_hit) begin
        r_state <= ST_TIMEOUT;
      end else begin
        r_cycles <= w_cycles_inc;
      end
    end
  end

`ifdef CORE_CYCLE_MONITOR_HEARTBEAT_EN
  logic r_heartbeat;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_heartbeat <= 1'b0;
    end else if (w_running && !w_term_write && !w_limit_hit) begin
      r_heartbeat <= (w_cycles_inc[HB_SHIFT-1:0] == '0);
    end else begin
      r_heartbeat <= 1'b0;
    end
  end

  assign io_heartbeat = r_heartbeat;
`endif

  assign io_cycles       = r_cycles;
  assign io_exit_code    = r_exit_code;
  assign io_state        = r_state;
  assign io_tohost_ready = w_running;
  assign io_finished     = !w_running;
  assign io_pass         = (r_state == ST_PASS);
  assign io_timeout      = (r_state == ST_TIMEOUT);

endmodule

// File: tb/tb_core_cycle_monitor.sv
// Bench for core_cycle_monitor: directed scenarios plus randomized runs, each
// checked against an abstract pass/fail/timeout model of the monitor.
module tb_core_cycle_monitor;

  localparam int WIDTH    = 8;
  localparam int HB_SHIFT = 4;
  localparam int MAXC     = (1 << WIDTH) - 1;
  localparam int EW       = 2 + WIDTH + 31 + 1;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] io_limit;
  logic             io_tohost_valid;
  logic             io_tohost_ready;
  logic [31:0]      io_tohost_bits;
  logic [WIDTH-1:0] io_cycles;
  logic             io_finished;
  logic             io_pass;
  logic [30:0]      io_exit_code;
  logic             io_timeout;
  logic [1:0]       io_state;
  logic             hb_obs;

  core_cycle_monitor #(.WIDTH(WIDTH), .HB_SHIFT(HB_SHIFT)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_limit        (io_limit),
    .io_tohost_valid (io_tohost_valid),
    .io_tohost_ready (io_tohost_ready),
    .io_tohost_bits  (io_tohost_bits),
    .io_cycles       (io_cycles),
    .io_finished     (io_finished),
    .io_pass         (io_pass),
    .io_exit_code    (io_exit_code),
    .io_timeout      (io_timeout),
    .io_state        (io_state)
`ifdef CORE_CYCLE_MONITOR_HEARTBEAT_EN
    ,
    .io_heartbeat    (hb_obs)
`endif
  );

`ifndef CORE_CYCLE_MONITOR_HEARTBEAT_EN
  assign hb_obs = 1'b0;
`endif

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: outcome codes 0=running 1=pass 2=fail 3=timeout
  int          m_outcome;
  int          m_cycles;
  logic [30:0] m_exit;
  bit          m_hb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_outcome = 0;
    m_cycles  = 0;
    m_exit    = '0;
    m_hb      = 1'b0;
  endtask

  // One clock edge of the monitor's rules, evaluated on the pre-edge inputs.
  task automatic model_edge(input bit v, input logic [31:0] b, input int lim);
    m_hb = 1'b0;
    if (m_outcome != 0) return;
    if (v && b[0]) begin
      m_outcome = (b == 32'd1) ? 1 : 2;
      m_exit    = (b == 32'd1) ? 31'd0 : b[31:1];
    end else if (lim != 0 && m_cycles >= lim) begin
      m_outcome = 3;
    end else begin
      m_cycles = (m_cycles + 1 > MAXC) ? MAXC : m_cycles + 1;
`ifdef CORE_CYCLE_MONITOR_HEARTBEAT_EN
      m_hb = (m_cycles % (1 << HB_SHIFT)) == 0;
`endif
    end
  endtask

  task automatic push_expected();
    exp_q.push_back({m_outcome[1:0], m_cycles[WIDTH-1:0], m_exit, m_hb});
  endtask

  task automatic compare_outputs(input string tag);
    logic [EW-1:0] e;
    logic [1:0]    e_st;
    bit            run;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
      return;
    end
    e    = exp_q.pop_front();
    e_st = e[EW-1 -: 2];
    run  = (e_st == 2'd0);
    check({tag, "_state"},  64'(io_state),     64'(e_st));
    check({tag, "_cycles"}, 64'(io_cycles),    64'(e[EW-3 -: WIDTH]));
    check({tag, "_exit"},   64'(io_exit_code), 64'(e[31:1]));
    check({tag, "_flags"},
          64'({io_tohost_ready, io_finished, io_pass, io_timeout}),
          64'({run, !run, e_st == 2'd1, e_st == 2'd3}));
`ifdef CORE_CYCLE_MONITOR_HEARTBEAT_EN
    check({tag, "_hb"}, 64'(hb_obs), 64'(e[0]));
`endif
  endtask

  // driver tasks (called at a falling edge, return at the next falling edge)
  task automatic cycle(input string tag, input bit v, input logic [31:0] b, input int lim);
    io_tohost_valid = v;
    io_tohost_bits  = b;
    io_limit        = lim[WIDTH-1:0];
    @(posedge clock);
    #1;
    model_edge(v, b, lim);
    push_expected();
    compare_outputs(tag);
    @(negedge clock);
  endtask

  task automatic idle(input string tag, input int n, input int lim);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 32'd0, lim);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #2;
    model_reset();
    push_expected();
    compare_outputs({tag, "_async"});
    @(negedge clock);
    io_tohost_valid = 1'b0;
    io_tohost_bits  = '0;
    io_limit        = '0;
    reset           = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    io_limit        = '0;
    io_tohost_valid = 1'b0;
    io_tohost_bits  = '0;
    model_reset();

    // free run, no limit
    do_reset("rst0");
    idle("run100", 100, 0);
    check("run100_count", 64'(io_cycles), 64'd100);

    // pass at cycle 50, then frozen
    do_reset("rst1");
    idle("pre_pass", 50, 0);
    cycle("pass_wr", 1'b1, 32'h1, 0);
    cycle("post_pass_wr", 1'b1, 32'h5, 0);
    idle("post_pass", 10, 3);
    check("pass_frozen", 64'(io_cycles), 64'd50);

    // fail with exit code 3, later writes ignored; even write ignored in RUN
    do_reset("rst2");
    idle("pre_fail", 7, 0);
    cycle("even_wr", 1'b1, 32'h4, 0);
    cycle("fail_wr", 1'b1, 32'h7, 0);
    cycle("fail_even", 1'b1, 32'h4, 0);
    cycle("fail_pass", 1'b1, 32'h1, 0);
    check("fail_code", 64'(io_exit_code), 64'd3);

    // async reset while in FAIL, heartbeat covers 16/32/48
    do_reset("rst_fail");
    idle("restart", 50, 0);

    // timeout at limit 10
    do_reset("rst3");
    idle("to10", 14, 10);
    check("to10_frozen", 64'(io_cycles), 64'd10);

    // pass write coincides with timeout condition
    do_reset("rst4");
    idle("pre_race", 10, 10);
    cycle("race_wr", 1'b1, 32'h1, 10);
    idle("post_race", 3, 10);

    // limit dropped below the current count mid-run
    do_reset("rst5");
    idle("lim_hi", 30, 200);
    cycle("lim_drop", 1'b0, 32'h0, 5);
    idle("lim_after", 3, 5);

    // counter saturation
    do_reset("rst6");
    idle("sat", MAXC + 12, 0);
    check("sat_value", 64'(io_cycles), 64'(MAXC));

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      int lim;
      do_reset("rst_rand");
      lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 80));
      for (int c = 0; c < 90; c++) begin
        bit          v;
        logic [31:0] b;
        v = ($urandom_range(0, 15) == 0);
        b = $urandom();
        if ($urandom_range(0, 3) != 0) b[0] = 1'b0;
        else if ($urandom_range(0, 1) == 0) b = 32'h1;
        if ($urandom_range(0, 40) == 0) lim = int'($urandom_range(0, 100));
        cycle("rand", v, b, lim);
      end
    end

    if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
